// File: rtl/gps_pkg.sv
// Shared UBX protocol constants and the frame sequencer state encoding.
// Contents:
//   UBX_SYNC1/UBX_SYNC2   frame preamble bytes
//   UBX_CLS_* / UBX_ID_*  class and message id codes used by the config ROM
//   state_e               sequencer FSM states
//   is_byte_state()       states that present a byte on the TX handshake
//   in_checksum()         states whose accepted byte feeds the Fletcher sums
package gps_pkg;

  localparam logic [7:0] UBX_SYNC1      = 8'hB5;
  localparam logic [7:0] UBX_SYNC2      = 8'h62;

  localparam logic [7:0] UBX_CLS_CFG    = 8'h06;
  localparam logic [7:0] UBX_ID_NAV5    = 8'h24;
  localparam logic [7:0] UBX_ID_MSG     = 8'h01;
  localparam logic [7:0] UBX_CLS_NAV    = 8'h01;
  localparam logic [7:0] UBX_ID_POSLLH  = 8'h02;
  localparam logic [7:0] UBX_ID_VELNED  = 8'h12;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC1,
    ST_SYNC2,
    ST_CLASS,
    ST_ID,
    ST_LEN_L,
    ST_LEN_H,
    ST_PAY,
    ST_CKA,
    ST_CKB,
    ST_GAP,
    ST_DONE
  } state_e;

  function automatic logic is_byte_state(input state_e s);
    return s inside {ST_SYNC1, ST_SYNC2, ST_CLASS, ST_ID, ST_LEN_L,
                     ST_LEN_H, ST_PAY, ST_CKA, ST_CKB};
  endfunction

  // Sync bytes and the checksum bytes themselves are excluded from the sums.
  function automatic logic in_checksum(input state_e s);
    return s inside {ST_CLASS, ST_ID, ST_LEN_L, ST_LEN_H, ST_PAY};
  endfunction

endpackage

// File: rtl/gps_cfg_payload_rom.sv
// Combinational table of UBX configuration messages.
// Ports:
//   msg  in   frame index 0..NUM_MSG-1
//   idx  in   payload byte index
//   cls  out  UBX class of frame msg
//   id   out  UBX message id of frame msg
//   len  out  payload length in bytes of frame msg
//   pay  out  payload byte idx of frame msg (00 past the defined bytes)
// Contents:
//   0  CFG-NAV5 len 36 : 01 00 07 00, then 32 x 00
//   1  CFG-MSG  len MSG1_LEN : 01 02 01 (enable NAV-POSLLH)
//   2  CFG-MSG  len 3  : 01 12 01 (enable NAV-VELNED)
// MSG1_LEN lets an integration shorten frame 1, e.g. to 0 to turn it into
// a poll request with no payload.
module gps_cfg_payload_rom
  import gps_pkg::*;
#(
  parameter int          NUM_MSG  = 3,
  parameter int          MAX_PAY  = 36,
  parameter logic [15:0] MSG1_LEN = 16'd3
) (
  input  logic [$clog2(NUM_MSG > 1 ? NUM_MSG : 2)-1:0] msg,
  input  logic [$clog2(MAX_PAY)-1:0]                   idx,
  output logic [7:0]                                   cls,
  output logic [7:0]                                   id,
  output logic [15:0]                                  len,
  output logic [7:0]                                   pay
);

  localparam int MW = $clog2(NUM_MSG > 1 ? NUM_MSG : 2);
  localparam int IW = $clog2(MAX_PAY);

  always_comb begin
    // NOTE: every output gets a default first so no path through the
    // branches below leaves a value unassigned and infers a latch.
    cls = 8'h00;
    id  = 8'h00;
    len = 16'd0;
    pay = 8'h00;
    if (msg == MW'(0)) begin
      cls = UBX_CLS_CFG;
      id  = UBX_ID_NAV5;
      len = 16'd36;
      // Mask = 0x0001 (dynamic model only), dynModel = 7 (airborne <2g).
      if (idx == IW'(0))      pay = 8'h01;
      else if (idx == IW'(2)) pay = 8'h07;
    end else if (msg == MW'(1)) begin
      cls = UBX_CLS_CFG;
      id  = UBX_ID_MSG;
      len = MSG1_LEN;
      if (idx == IW'(0))      pay = UBX_CLS_NAV;
      else if (idx == IW'(1)) pay = UBX_ID_POSLLH;
      else if (idx == IW'(2)) pay = 8'h01;
    end else if (msg == MW'(2)) begin
      cls = UBX_CLS_CFG;
      id  = UBX_ID_MSG;
      len = 16'd3;
      if (idx == IW'(0))      pay = UBX_CLS_NAV;
      else if (idx == IW'(1)) pay = UBX_ID_VELNED;
      else if (idx == IW'(2)) pay = 8'h01;
    end
  end

endmodule

// File: rtl/gps_cfg_sequencer.sv
// Streams NUM_MSG UBX configuration frames to the UART transmitter after a
// start pulse. Sync bytes, the little-endian length and the Fletcher
// CK_A/CK_B are generated here; class, id, length and payload come from
// gps_cfg_payload_rom. Frames are separated by GAP_CYC idle cycles.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset, wins over every input
//   start     in   one-cycle pulse, ignored while busy or during rst
//   busy      out  high from the cycle after an accepted start until done
//   done      out  one-cycle pulse after the final CK_B is accepted
//   tx_data   out  byte offered to the UART
//   tx_valid  out  tx_data valid; held until tx_ready is seen
//   tx_ready  in   UART accepts the byte when tx_valid && tx_ready
//   msg_num   out  index of the frame being sent, valid while busy
module gps_cfg_sequencer
  import gps_pkg::*;
#(
  parameter int          NUM_MSG  = 3,
  parameter int          MAX_PAY  = 36,
  parameter int          GAP_CYC  = 16,
  parameter logic [15:0] MSG1_LEN = 16'd3
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  output logic                                         busy,
  output logic                                         done,
  output logic [7:0]                                   tx_data,
  output logic                                         tx_valid,
  input  logic                                         tx_ready,
  output logic [$clog2(NUM_MSG > 1 ? NUM_MSG : 2)-1:0] msg_num
);

  localparam int              MW       = $clog2(NUM_MSG > 1 ? NUM_MSG : 2);
  localparam int              IW       = $clog2(MAX_PAY);
  localparam logic [MW-1:0]   LAST_MSG = MW'(NUM_MSG - 1);
  localparam logic [IW-1:0]   LAST_IDX = IW'(MAX_PAY - 1);
  localparam logic [15:0]     GAP_LOAD = 16'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);

  state_e          state_q, state_d;
  logic [MW-1:0]   msg_q, msg_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [15:0]     len_q, len_d;
  logic [15:0]     gap_q, gap_d;
  logic [7:0]      ck_a_q, ck_a_d;
  logic [7:0]      ck_b_q, ck_b_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            accept;
  logic            last_pay;
  logic            sync1_entry;
  logic [7:0]      rom_cls, rom_id, rom_pay;
  logic [15:0]     rom_len;

  // The ROM is addressed with the next-cycle frame/index so the byte for the
  // next state can be registered onto tx_data.
  gps_cfg_payload_rom #(
    .NUM_MSG  (NUM_MSG),
    .MAX_PAY  (MAX_PAY),
    .MSG1_LEN (MSG1_LEN)
  ) u_rom (
    .msg (msg_d),
    .idx (idx_d),
    .cls (rom_cls),
    .id  (rom_id),
    .len (rom_len),
    .pay (rom_pay)
  );

  assign accept = tx_valid_q & tx_ready;

  // Stop at len-1, and never walk past the ROM's payload depth even if a
  // table entry claims a longer payload.
  assign last_pay = ((16'(idx_q) + 16'd1) >= len_q) || (idx_q == LAST_IDX);

  // Next state, counters and checksum. The byte being accepted is exactly
  // tx_data_q, so the sums are built from the registered output.
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    ck_a_d  = ck_a_q;
    ck_b_d  = ck_b_q;

    if (accept && in_checksum(state_q)) begin
      ck_a_d = ck_a_q + tx_data_q;
      ck_b_d = ck_b_q + ck_a_q + tx_data_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SYNC1;
          msg_d   = '0;
        end
      end
      ST_SYNC1: if (accept) state_d = ST_SYNC2;
      ST_SYNC2: if (accept) state_d = ST_CLASS;
      ST_CLASS: if (accept) state_d = ST_ID;
      ST_ID:    if (accept) state_d = ST_LEN_L;
      ST_LEN_L: if (accept) state_d = ST_LEN_H;
      ST_LEN_H: begin
        if (accept) begin
          idx_d   = '0;
          state_d = (len_q == 16'd0) ? ST_CKA : ST_PAY;
        end
      end
      ST_PAY: begin
        if (accept) begin
          if (last_pay) state_d = ST_CKA;
          else          idx_d   = idx_q + IW'(1);
        end
      end
      ST_CKA: if (accept) state_d = ST_CKB;
      ST_CKB: begin
        if (accept) begin
          if (msg_q == LAST_MSG) begin
            state_d = ST_DONE;
          end else begin
            msg_d = msg_q + MW'(1);
            if (GAP_CYC == 0) begin
              state_d = ST_SYNC1;
            end else begin
              state_d = ST_GAP;
              gap_d   = GAP_LOAD;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_q == 16'd0) state_d = ST_SYNC1;
        else                gap_d   = gap_q - 16'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (sync1_entry) begin
      ck_a_d = 8'h00;
      ck_b_d = 8'h00;
    end
  end

  // Registered outputs are decoded from the next state. A stalled state
  // recomputes the same byte because nothing it depends on has moved.
  assign sync1_entry = (state_d == ST_SYNC1) && (state_q != ST_SYNC1);

  always_comb begin
    tx_valid_d = is_byte_state(state_d);
    busy_d     = !(state_d inside {ST_IDLE, ST_DONE});
    done_d     = (state_d == ST_DONE);
    len_d      = sync1_entry ? rom_len : len_q;
    case (state_d)
      ST_SYNC1: tx_data_d = UBX_SYNC1;
      ST_SYNC2: tx_data_d = UBX_SYNC2;
      ST_CLASS: tx_data_d = rom_cls;
      ST_ID:    tx_data_d = rom_id;
      ST_LEN_L: tx_data_d = len_q[7:0];
      ST_LEN_H: tx_data_d = len_q[15:8];
      ST_PAY:   tx_data_d = rom_pay;
      ST_CKA:   tx_data_d = ck_a_d;
      ST_CKB:   tx_data_d = ck_b_d;
      default:  tx_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= ST_IDLE;
      msg_q      <= '0;
      idx_q      <= '0;
      len_q      <= 16'd0;
      gap_q      <= 16'd0;
      ck_a_q     <= 8'h00;
      ck_b_q     <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      msg_q      <= msg_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
      ck_a_q     <= ck_a_d;
      ck_b_q     <= ck_b_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign msg_num  = msg_q;

endmodule

// File: tb/tb_gps_cfg_sequencer.sv
// Directed bench for gps_cfg_sequencer. dut0 uses the default table and a
// 16-cycle gap; dut1 shortens frame 1 to a zero-length payload with no gap.
`timescale 1ns/1ps
module tb_gps_cfg_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b1, start0 = 1'b0, ready0 = 1'b0;
  logic       busy0, done0, valid0;
  logic [7:0] data0;
  logic [1:0] msg0;

  logic       rst1 = 1'b1, start1 = 1'b0, ready1 = 1'b0;
  logic       busy1, done1, valid1;
  logic [7:0] data1;
  logic [1:0] msg1;

  gps_cfg_sequencer #(.NUM_MSG(3), .MAX_PAY(36), .GAP_CYC(16)) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .busy(busy0), .done(done0),
    .tx_data(data0), .tx_valid(valid0), .tx_ready(ready0), .msg_num(msg0));

  gps_cfg_sequencer #(.NUM_MSG(3), .MAX_PAY(36), .GAP_CYC(0), .MSG1_LEN(16'd0)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .busy(busy1), .done(done1),
    .tx_data(data1), .tx_valid(valid1), .tx_ready(ready1), .msg_num(msg1));

  // Selects which instance the run/verify tasks drive and observe.
  logic       sel = 1'b0;
  logic       o_busy, o_done, o_valid;
  logic [7:0] o_data;
  logic [1:0] o_msg;
  always_comb begin
    o_busy  = sel ? busy1  : busy0;
    o_done  = sel ? done1  : done0;
    o_valid = sel ? valid1 : valid0;
    o_data  = sel ? data1  : data0;
    o_msg   = sel ? msg1   : msg0;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic rd);
    if (sel) begin rst1 = r; start1 = s; ready1 = rd; end
    else     begin rst0 = r; start0 = s; ready0 = rd; end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed frames.
  logic [7:0] f0_head [10] = '{8'hB5, 8'h62, 8'h06, 8'h24, 8'h24, 8'h00, 8'h01, 8'h00, 8'h07, 8'h00};
  logic [7:0] f1_full [11] = '{8'hB5, 8'h62, 8'h06, 8'h01, 8'h03, 8'h00, 8'h01, 8'h02, 8'h01, 8'h0E, 8'h47};
  logic [7:0] f1_zero [8]  = '{8'hB5, 8'h62, 8'h06, 8'h01, 8'h00, 8'h00, 8'h07, 8'h1B};
  logic [7:0] f2_full [11] = '{8'hB5, 8'h62, 8'h06, 8'h01, 8'h03, 8'h00, 8'h01, 8'h12, 8'h01, 8'h1E, 8'h67};

  logic [7:0] exp_q [$];
  int         exp_start_q [$];

  task automatic build_expected(input logic zero_len1);
    exp_q.delete();
    exp_start_q.delete();
    exp_start_q.push_back(0);
    for (int i = 0; i < 10; i++) exp_q.push_back(f0_head[i]);
    for (int i = 0; i < 32; i++) exp_q.push_back(8'h00);
    exp_q.push_back(8'h56);
    exp_q.push_back(8'hD6);
    exp_start_q.push_back(exp_q.size());
    if (zero_len1) for (int i = 0; i < 8; i++)  exp_q.push_back(f1_zero[i]);
    else           for (int i = 0; i < 11; i++) exp_q.push_back(f1_full[i]);
    exp_start_q.push_back(exp_q.size());
    for (int i = 0; i < 11; i++) exp_q.push_back(f2_full[i]);
  endtask

  // Observations of one run.
  logic [7:0] got_q [$];
  logic [1:0] got_msg_q [$];
  int         gaps_q [$];
  int         done_cnt, done_cyc, last_acc_cyc, stall_bad, post_done_valid;
  logic       first_valid, busy_at_done;

  // ready_mode 0: tx_ready tied high; 1: random ~50% stalls.
  // poke_at >= 0: pulse start again once that many bytes were accepted.
  // abort_at >= 0: return (leaving the frame in flight) at that byte count.
  task automatic run(input int ready_mode, input int poke_at, input int abort_at, input int budget);
    int   cyc, idle_run;
    logic poked, prev_stall, rd;
    logic [7:0] prev_data;
    got_q.delete(); got_msg_q.delete(); gaps_q.delete();
    done_cnt = 0; done_cyc = -1; last_acc_cyc = -1; stall_bad = 0; post_done_valid = 0;
    first_valid = 1'b0; busy_at_done = 1'b1;
    cyc = 0; idle_run = 0; poked = 1'b0; prev_stall = 1'b0; prev_data = 8'h00;
    drive(1'b0, 1'b1, 1'b1);
    step();
    while (cyc < budget) begin
      if (abort_at >= 0 && got_q.size() == abort_at) break;
      rd = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (poke_at >= 0 && !poked && got_q.size() == poke_at) begin
        drive(1'b0, 1'b1, rd);
        poked = 1'b1;
      end else begin
        drive(1'b0, 1'b0, rd);
      end
      if (cyc == 0) first_valid = o_valid;
      if (prev_stall && (!o_valid || o_data !== prev_data)) stall_bad++;
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = o_busy;
      end
      if (done_cnt > 0 && cyc > done_cyc && o_valid) post_done_valid++;
      if (o_valid && rd) begin
        got_q.push_back(o_data);
        got_msg_q.push_back(o_msg);
        if (idle_run > 0) gaps_q.push_back(idle_run);
        idle_run = 0;
        last_acc_cyc = cyc;
      end else if (!o_valid && o_busy) begin
        idle_run++;
      end
      prev_stall = o_valid && !rd;
      prev_data  = o_data;
      if (done_cnt > 0 && cyc >= done_cyc + 4) break;
      step();
      cyc++;
    end
    drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic verify(input string name, input int exp_gap_cnt, input int exp_gap_len);
    check({name, "/first_valid"}, 32'(first_valid), 32'd1);
    check({name, "/byte_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s/byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    for (int f = 0; f < 3; f++)
      if (exp_start_q[f] < got_msg_q.size())
        check($sformatf("%s/msg_num_frame%0d", name, f), 32'(got_msg_q[exp_start_q[f]]), f);
    check({name, "/done_count"}, done_cnt, 1);
    check({name, "/done_latency"}, done_cyc - last_acc_cyc, 1);
    check({name, "/busy_at_done"}, 32'(busy_at_done), 32'd0);
    check({name, "/valid_after_done"}, post_done_valid, 0);
    check({name, "/stall_stability"}, stall_bad, 0);
    check({name, "/gap_count"}, gaps_q.size(), exp_gap_cnt);
    for (int i = 0; i < gaps_q.size(); i++)
      check($sformatf("%s/gap%0d", name, i), gaps_q[i], exp_gap_len);
  endtask

  initial begin
    // Reset with start held: start during rst must be ignored.
    rst0 = 1'b1; start0 = 1'b1; ready0 = 1'b1;
    rst1 = 1'b1; start1 = 1'b1; ready1 = 1'b1;
    step();
    step();
    sel = 1'b0;
    check("reset/busy",     32'(o_busy),  32'd0);
    check("reset/done",     32'(o_done),  32'd0);
    check("reset/tx_valid", 32'(o_valid), 32'd0);
    check("reset/tx_data",  32'(o_data),  32'h00);
    check("reset/msg_num",  32'(o_msg),   32'd0);
    rst0 = 1'b0; start0 = 1'b0; rst1 = 1'b0; start1 = 1'b0;
    step();
    step();
    check("idle/tx_valid", 32'(o_valid), 32'd0);
    check("idle/busy",     32'(o_busy),  32'd0);

    // Full sequence, tx_ready high: frames back to back with 16-cycle gaps.
    build_expected(1'b0);
    run(0, -1, -1, 1000);
    verify("t1_full", 2, 16);

    // Random stalls: identical stream, stable data while stalled.
    repeat (3) step();
    run(1, -1, -1, 2000);
    verify("t3_stall", 2, 16);

    // start pulsed mid frame 1 has no effect.
    repeat (3) step();
    run(0, 50, -1, 1000);
    verify("t4_restart", 2, 16);

    // rst inside frame 0 payload, then a fresh start.
    repeat (3) step();
    run(0, -1, 10, 1000);
    check("t5/abort_point", got_q.size(), 10);
    drive(1'b1, 1'b0, 1'b1);
    step();
    check("t5/rst_tx_valid", 32'(o_valid), 32'd0);
    check("t5/rst_busy",     32'(o_busy),  32'd0);
    check("t5/rst_msg_num",  32'(o_msg),   32'd0);
    drive(1'b0, 1'b0, 1'b1);
    step();
    run(0, -1, -1, 1000);
    verify("t5_after_rst", 2, 16);

    // Zero-length frame 1, no inter-frame gap.
    sel = 1'b1;
    build_expected(1'b1);
    run(0, -1, -1, 1000);
    verify("t6_len0", 0, 0);
    check("t6/total_cycles", last_acc_cyc + 1, exp_q.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
